// File: rtl/adder_serial_para.sv
// Word-serial N-bit adder/subtractor: W bits per cycle over K = N/W OP cycles,
// carry held in a register between chunks, start/ready/done_tick handshake.

module adder_serial_para_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  assign {co, s} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
endmodule

module adder_serial_para #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         done_tick,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  localparam int K  = N / W;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   a_reg, b_reg;
  logic [N-1:0]   a_sh, b_sh, sum_sh;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           a_msb, b_msb;
  logic [W-1:0]   s;
  logic           c;

  adder_serial_para_chunk #(.W(W)) u_chunk (
    .x  (a_reg[W-1:0]),
    .y  (b_reg[W-1:0]),
    .ci (carry),
    .s  (s),
    .co (c)
  );

  // Result enters from the top so after K chunks the LSB chunk sits at bit 0.
  if (W == N) begin : g_single
    assign sum_sh = s;
    assign a_sh   = '0;
    assign b_sh   = '0;
  end else begin : g_multi
    assign sum_sh = {s, sum[N-1:W]};
    assign a_sh   = {{W{1'b0}}, a_reg[N-1:W]};
    assign b_sh   = {{W{1'b0}}, b_reg[N-1:W]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = OP;
      OP:      if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    done_tick = 1'b0;
    case (state)
      IDLE:    ready     = 1'b1;
      DONE:    done_tick = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          // Subtraction is a + ~b + 1: invert b here, inject the +1 as carry-in.
          a_reg <= a;
          b_reg <= sub ? ~b : b;
          carry <= sub;
          cnt   <= CW'(K - 1);
          a_msb <= a[N-1];
          b_msb <= sub ? ~b[N-1] : b[N-1];
        end
        OP: begin
          sum   <= sum_sh;
          a_reg <= a_sh;
          b_reg <= b_sh;
          carry <= c;
          if (cnt == '0) begin
            cout <= c;
            ovf  <= (a_msb == b_msb) && (s[W-1] != a_msb);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_serial_para.sv
// Bench for adder_serial_para: directed table at N=32/W=8, multi-cycle corner
// sequences, and a randomized scoreboard sweep over several (N,W) pairs.

module tb_adder_serial_para;
  localparam int MK = 4;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    int          stamp;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        o;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pcyc  = 0;
  int sweep_done = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // main DUT, N=32 W=8
  logic        rst_n, srst_n;
  logic        m_start, m_sub, m_ready, m_done, m_cout, m_ovf;
  logic [31:0] m_a, m_b, m_sum;
  exp_t        mq[$];
  exp_t        me;
  int          m_ndone = 0;

  adder_serial_para #(.N(32), .W(8)) u_main (
    .clk(clk), .reset_n(rst_n), .start(m_start), .sub(m_sub), .a(m_a), .b(m_b),
    .ready(m_ready), .done_tick(m_done), .sum(m_sum), .cout(m_cout), .ovf(m_ovf)
  );

  always @(negedge clk) begin
    if (m_done) begin
      m_ndone++;
      if (mq.size() == 0) begin
        total++; bad++;
        $display("FAIL main_spurious_done: got done_tick=1 want no pending op");
      end else begin
        me = mq.pop_front();
        chk("main_sum",  m_sum,  me.s);
        chk("main_cout", {31'b0, m_cout}, {31'b0, me.c});
        chk("main_ovf",  {31'b0, m_ovf},  {31'b0, me.o});
        chk("main_latency", pcyc - me.stamp + 1, MK + 1);
      end
    end
  end

  task automatic m_wait_ready();
    int n = 0;
    @(negedge clk);
    while (!m_ready && n < 100) begin @(negedge clk); n++; end
    if (!m_ready) begin total++; bad++; $display("FAIL main_ready_timeout: got ready=0 want 1"); end
  endtask

  task automatic m_issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [31:0] s, input logic c, input logic o);
    exp_t e;
    m_wait_ready();
    @(posedge clk); #1;
    m_a = a; m_b = b; m_sub = sub; m_start = 1'b1;
    @(posedge clk); #1;
    e.s = s; e.c = c; e.o = o; e.stamp = pcyc;
    mq.push_back(e);
    m_start = 1'b0;
  endtask

  task automatic m_drain();
    int n = 0;
    while (mq.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (mq.size() != 0) begin total++; bad++; $display("FAIL main_drain_timeout: got %0d pending want 0", mq.size()); end
  endtask

  vec_t vt[8];

  initial begin
    int nd0;
    vt[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vt[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vt[2] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vt[3] = '{32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vt[4] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0};
    vt[5] = '{32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vt[6] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vt[7] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};

    m_start = 0; m_sub = 0; m_a = 0; m_b = 0;
    rst_n = 0; srst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, m_ready}, 32'd1);
    chk("rst_done",  {31'b0, m_done},  32'd0);
    chk("rst_sum",   m_sum, 32'd0);
    chk("rst_cout",  {31'b0, m_cout}, 32'd0);
    chk("rst_ovf",   {31'b0, m_ovf},  32'd0);
    rst_n = 1; srst_n = 1;

    foreach (vt[i]) begin
      m_issue(vt[i].a, vt[i].b, vt[i].sub, vt[i].s, vt[i].c, vt[i].o);
      m_drain();
    end

    // back-to-back issue; ready must be low mid-OP and results hold after done
    m_issue(32'h00000100, 32'h000000FF, 1'b0, 32'h000001FF, 1'b0, 1'b0);
    @(negedge clk);
    chk("op_ready_low", {31'b0, m_ready}, 32'd0);
    m_issue(32'h00000001, 32'h00000002, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    m_drain();
    repeat (2) @(negedge clk);
    chk("hold_sum",  m_sum, 32'hFFFFFFFF);
    chk("hold_cout", {31'b0, m_cout}, 32'd0);

    // start held high with changing operands through OP and DONE
    nd0 = m_ndone;
    m_issue(32'h00000010, 32'h00000020, 1'b0, 32'h00000030, 1'b0, 1'b0);
    m_a = 32'hDEADBEEF; m_b = 32'h00000001; m_sub = 1'b1; m_start = 1'b1;
    repeat (MK + 1) @(posedge clk);
    #1 m_start = 1'b0;
    m_drain();
    repeat (4) @(negedge clk);
    chk("held_start_one_done", m_ndone - nd0, 32'd1);

    // reset asserted during the second OP cycle
    nd0 = m_ndone;
    m_issue(32'hFFFF0000, 32'h00000001, 1'b0, 32'hFFFF0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    mq.delete();
    chk("midrst_ready", {31'b0, m_ready}, 32'd1);
    chk("midrst_sum",   m_sum, 32'd0);
    chk("midrst_cout",  {31'b0, m_cout}, 32'd0);
    chk("midrst_ovf",   {31'b0, m_ovf},  32'd0);
    chk("midrst_done",  {31'b0, m_done}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (MK + 3) @(negedge clk);
    chk("midrst_no_done", m_ndone - nd0, 32'd0);
    m_issue(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0);
    m_drain();

    begin
      int n = 0;
      while (sweep_done < 4 && n < 80000) begin @(posedge clk); n++; end
      if (sweep_done < 4) begin total++; bad++; $display("FAIL sweep_timeout: got %0d done want 4", sweep_done); end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // randomized sweep, one DUT per (N,W)
  for (genvar g = 0; g < 4; g++) begin : sw
    localparam int NN = (g == 0) ? 8 : (g == 1) ? 8 : (g == 2) ? 12 : 32;
    localparam int WW = (g == 0) ? 4 : (g == 1) ? 8 : (g == 2) ? 3  : 1;
    localparam int KK = NN / WW;

    logic          st, sb, rdy, dt, co, ov;
    logic [NN-1:0] aa, bb, sm, be;
    logic [NN:0]   full;
    exp_t          q[$];
    exp_t          e;

    adder_serial_para #(.N(NN), .W(WW)) u (
      .clk(clk), .reset_n(srst_n), .start(st), .sub(sb), .a(aa), .b(bb),
      .ready(rdy), .done_tick(dt), .sum(sm), .cout(co), .ovf(ov)
    );

    always @(negedge clk) begin
      if (dt) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL sw%0d_spurious_done: got done_tick=1 want no pending op", g);
        end else begin
          e = q.pop_front();
          chk($sformatf("sw%0d_sum", g),  32'(sm), e.s);
          chk($sformatf("sw%0d_cout", g), {31'b0, co}, {31'b0, e.c});
          chk($sformatf("sw%0d_ovf", g),  {31'b0, ov}, {31'b0, e.o});
          chk($sformatf("sw%0d_lat", g),  pcyc - e.stamp + 1, KK + 1);
        end
      end
    end

    initial begin
      exp_t x;
      int n;
      st = 0; sb = 0; aa = '0; bb = '0;
      @(posedge srst_n);
      for (int i = 0; i < 1000; i++) begin
        n = 0;
        @(negedge clk);
        while (!rdy && n < 100) begin @(negedge clk); n++; end
        if (!rdy) begin total++; bad++; $display("FAIL sw%0d_ready_timeout: got ready=0 want 1", g); end
        @(posedge clk); #1;
        aa = NN'($urandom);
        bb = NN'($urandom);
        sb = 1'($urandom);
        st = 1'b1;
        be   = sb ? ~bb : bb;
        full = {1'b0, aa} + {1'b0, be} + {{NN{1'b0}}, sb};
        x.s  = 32'(full[NN-1:0]);
        x.c  = full[NN];
        x.o  = (aa[NN-1] == be[NN-1]) && (full[NN-1] != aa[NN-1]);
        @(posedge clk); #1;
        x.stamp = pcyc;
        q.push_back(x);
        st = 1'b0;
      end
      n = 0;
      while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
      if (q.size() != 0) begin total++; bad++; $display("FAIL sw%0d_drain_timeout: got %0d pending want 0", g, q.size()); end
      sweep_done++;
    end
  end
endmodule
